regset_sweep: RTL and testbench
===============================

Name: regset_sweep

Overview:
- Parametrised successor register set for the RudolV core: two read ports and one write port, with a per-entry grubby tag field of configurable width.
- Unlike the BRAM-preinit variants, it does not rely on an initial block. After reset, and on request, a hardware sweep FSM writes zero to every entry, so the block works on FPGAs and ASICs without BRAM preinit.
- Sits in the decode/execute stage in place of the RegSet* family; busy gates the pipeline while a sweep runs.

Parameters:
- WIDTH, 32, data bits per entry.
- ADDR_W, 6, address bits; depth = 2**ADDR_W (64 covers x0-x31 plus CSR/shadow bank).
- TAG_W, 1, grubby tag bits per entry (>=1).
- ZERO_R0, 1, when 1 address 0 always reads data=0, tag=0.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- clr  in  1  request a full sweep (single-cycle pulse or level).
- busy  out  1  sweep in progress; external writes ignored, reads return 0.
- we  in  1  write enable.
- wa  in  ADDR_W  write address.
- wd  in  WIDTH  write data.
- wg  in  TAG_W  write tag.
- ra1  in  ADDR_W  read address port 1.
- ra2  in  ADDR_W  read address port 2.
- rd1  out  WIDTH  read data port 1, registered.
- rg1  out  TAG_W  read tag port 1, registered.
- rd2  out  WIDTH  read data port 2, registered.
- rg2  out  TAG_W  read tag port 2, registered.

Behaviour:
- Storage array: 2**ADDR_W x (WIDTH+TAG_W). It is not reset by rstn; only the sweep clears it.
- Reset (rstn low, async):
  - rd1, rd2, rg1, rg2 = 0.
  - FSM = SWEEP, sweep counter = 0, busy = 1.
- FSM states: SWEEP, RUN.
- SWEEP:
  - Each cycle writes {0,0} to entry[counter], then counter increments.
  - When counter == 2**ADDR_W-1 that write completes and next state = RUN, busy = 0.
  - Sweep length is exactly 2**ADDR_W cycles after rstn deasserts (64 at default).
- RUN:
  - clr = 1 → next state SWEEP, counter = 0, busy = 1 from the next cycle. A write presented in the same cycle as clr is still performed; the sweep later zeroes it.
- clr during SWEEP restarts the counter at 0; the sweep completes 2**ADDR_W cycles after the last clr.
- External we during SWEEP is dropped silently; the pipeline must hold the write until busy = 0.
- Read latency: 1 cycle. rdN/rgN reflect raN sampled at the previous edge.
- During SWEEP, rdN/rgN load 0 every cycle regardless of raN.
- ZERO_R0 = 1:
  - raN == 0 yields rdN = 0 and rgN = 0.
  - Writes to address 0 update the array but are never visible.
- Read-during-write (we = 1, wa == raN, RUN): result defined by REGSET_BYPASS_EN (see Optional Feature). The ZERO_R0 rule takes priority over bypass.
- Both read ports may address the same entry; both return identical values.
- Reset mid-sweep: restarts the sweep from 0.
- Width rules: wg is stored verbatim. No truncation or extension anywhere; all buses are exact-width.

Optional Feature:
- Macro: REGSET_BYPASS_EN.
- Defined: write-first. If we = 1, busy = 0 and wa == raN (with raN != 0 when ZERO_R0 = 1), then next-cycle rdN = wd and rgN = wg.
- Undefined: read-first. rdN/rgN return the entry contents before the write; the new value is visible from the following read. No bypass muxes are synthesised.

Test Plan:
- Release rstn, hold clr = 0 → busy = 1 for exactly 64 cycles, then 0. Read all 64 addresses → rd = 0x00000000, rg = 0 for each.
- After sweep: write wa = 5, wd = 0xDEADBEEF, wg = 1; next cycle ra1 = 5, ra2 = 5 → one cycle later rd1 = rd2 = 0xDEADBEEF, rg1 = rg2 = 1.
- Write wa = 0, wd = 0x12345678 with ZERO_R0 = 1; read ra1 = 0 → rd1 = 0, rg1 = 0.
- Same-cycle we = 1, wa = 7, wd = 0xA5A5A5A5, ra1 = 7, old value 0x11111111 → rd1 = 0xA5A5A5A5 with REGSET_BYPASS_EN, rd1 = 0x11111111 without.
- After writing 0xCAFEF00D to wa = 9: pulse clr, assert clr again 10 cycles later → busy stays 1 for 74 cycles total. A we to wa = 3 during busy is dropped. Afterwards ra1 = 9 → 0 and ra1 = 3 → 0.
- Pull rstn low at sweep cycle 30, release → busy = 1 for a fresh 64 cycles; rd1 = rd2 = 0 immediately on reset assertion.

Source files
------------

// File: rtl/regset_sweep.sv
// Two-read/one-write register set with per-entry tag; a hardware sweep zeroes every entry after reset and on clr.
// Optional define REGSET_BYPASS_EN selects write-first read-during-write (default build is read-first).
module regset_sweep #(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 6,
   parameter int TAG_W   = 1,
   parameter int ZERO_R0 = 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              clr,
   output logic              busy,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [WIDTH-1:0]  wd,
   input  logic [TAG_W-1:0]  wg,
   input  logic [ADDR_W-1:0] ra1,
   input  logic [ADDR_W-1:0] ra2,
   output logic [WIDTH-1:0]  rd1,
   output logic [TAG_W-1:0]  rg1,
   output logic [WIDTH-1:0]  rd2,
   output logic [TAG_W-1:0]  rg2
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int EW    = WIDTH + TAG_W;

   typedef enum logic {S_SWEEP, S_RUN} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_cnt;
   logic              r_busy;
   logic [WIDTH-1:0]  r_rd1, r_rd2;
   logic [TAG_W-1:0]  r_rg1, r_rg2;
   logic [EW-1:0]     r_mem [DEPTH];

   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [EW-1:0]     w_mem_data;
   logic [EW-1:0]     w_rd1_nxt, w_rd2_nxt;

   // The sweep owns the single write port; external writes only land in RUN.
   assign w_mem_we   = (r_state == S_SWEEP) || we;
   assign w_mem_addr = (r_state == S_SWEEP) ? r_cnt : wa;
   assign w_mem_data = (r_state == S_SWEEP) ? '0 : {wd, wg};

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
   end

   always_comb begin
      w_rd1_nxt = r_mem[ra1];
      w_rd2_nxt = r_mem[ra2];
`ifdef REGSET_BYPASS_EN
      if (we && (wa == ra1)) w_rd1_nxt = {wd, wg};
      if (we && (wa == ra2)) w_rd2_nxt = {wd, wg};
`endif
      // Hard-wired zero register wins over any bypass.
      if ((ZERO_R0 != 0) && (ra1 == '0)) w_rd1_nxt = '0;
      if ((ZERO_R0 != 0) && (ra2 == '0)) w_rd2_nxt = '0;
      if (r_state == S_SWEEP) begin
         w_rd1_nxt = '0;
         w_rd2_nxt = '0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_SWEEP;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
         r_rd1   <= '0;
         r_rg1   <= '0;
         r_rd2   <= '0;
         r_rg2   <= '0;
      end else begin
         {r_rd1, r_rg1} <= w_rd1_nxt;
         {r_rd2, r_rg2} <= w_rd2_nxt;
         case (r_state)
            S_SWEEP: begin
               if (clr) begin
                  r_cnt <= '0;
               end else if (r_cnt == {ADDR_W{1'b1}}) begin
                  r_state <= S_RUN;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + ADDR_W'(1);
               end
            end
            S_RUN: begin
               if (clr) begin
                  r_state <= S_SWEEP;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            default: r_state <= S_SWEEP;
         endcase
      end
   end

   assign busy = r_busy;
   assign rd1  = r_rd1;
   assign rg1  = r_rg1;
   assign rd2  = r_rd2;
   assign rg2  = r_rg2;

endmodule

// File: tb/tb_regset_sweep.sv
// Randomised bench for regset_sweep against an array-based reference model; honours REGSET_BYPASS_EN.
module tb_regset_sweep;

   localparam int DEPTH = 64;
   localparam bit ZR0   = 1'b1;
`ifdef REGSET_BYPASS_EN
   localparam bit BYP   = 1'b1;
`else
   localparam bit BYP   = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        clr = 1'b0;
   logic        we = 1'b0;
   logic [5:0]  wa = '0, ra1 = '0, ra2 = '0;
   logic [31:0] wd = '0;
   logic [0:0]  wg = '0;
   logic        busy;
   logic [31:0] rd1, rd2;
   logic [0:0]  rg1, rg2;

   regset_sweep dut (
      .clk(clk), .rstn(rstn), .clr(clr), .busy(busy),
      .we(we), .wa(wa), .wd(wd), .wg(wg),
      .ra1(ra1), .ra2(ra2),
      .rd1(rd1), .rg1(rg1), .rd2(rd2), .rg2(rg2)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference state: contents as the program sees them, plus sweep edges still to run.
   logic [31:0] m_dat [DEPTH];
   logic        m_tag [DEPTH];
   int          m_left;
   logic [31:0] e_rd1, e_rd2;
   logic        e_rg1, e_rg2;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_read(input logic [5:0] r, input logic w, input logic [5:0] a,
                             input logic [31:0] d, input logic g,
                             output logic [31:0] od, output logic og);
      if (ZR0 && r == 0) begin
         od = '0; og = 1'b0;
      end else if (BYP && w && a == r) begin
         od = d; og = g;
      end else begin
         od = m_dat[r]; og = m_tag[r];
      end
   endtask

   // Apply one set of inputs at a falling edge, advance the model, check after the next rising edge.
   task automatic cycle(input logic c, input logic w, input logic [5:0] a, input logic [31:0] d,
                        input logic g, input logic [5:0] r1, input logic [5:0] r2);
      clr = c; we = w; wa = a; wd = d; wg = g; ra1 = r1; ra2 = r2;
      if (m_left > 0) begin
         e_rd1 = '0; e_rg1 = 1'b0; e_rd2 = '0; e_rg2 = 1'b0;
         m_left = c ? DEPTH : m_left - 1;
         if (m_left == 0)
            for (int i = 0; i < DEPTH; i++) begin m_dat[i] = '0; m_tag[i] = 1'b0; end
      end else begin
         model_read(r1, w, a, d, g, e_rd1, e_rg1);
         model_read(r2, w, a, d, g, e_rd2, e_rg2);
         if (w) begin m_dat[a] = d; m_tag[a] = g; end
         if (c) m_left = DEPTH;
      end
      @(posedge clk);
      @(negedge clk);
      check("busy", 64'(busy), 64'(m_left > 0));
      check("rd1", 64'(rd1), 64'(e_rd1));
      check("rg1", 64'(rg1), 64'(e_rg1));
      check("rd2", 64'(rd2), 64'(e_rd2));
      check("rg2", 64'(rg2), 64'(e_rg2));
   endtask

   // Run while busy with random traffic (writes must be dropped); optional clr at iteration reclr_at.
   task automatic run_sweep(input int reclr_at, output int n);
      n = 0;
      while (busy === 1'b1 && n < 300) begin
         cycle(n == reclr_at, 1'b1, (n == 20) ? 6'd3 : 6'($urandom_range(0, 63)),
               $urandom, 1'($urandom), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
         n++;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd1);
      check("rst_rd1", 64'(rd1), 64'd0);
      check("rst_rd2", 64'(rd2), 64'd0);
      check("rst_rg1", 64'(rg1), 64'd0);
      m_left = DEPTH;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < DEPTH; i++) begin m_dat[i] = 32'h0BAD0BAD; m_tag[i] = 1'b1; end
      repeat (3) @(negedge clk);
      do_reset();

      // Power-on sweep, then every address reads back zero.
      run_sweep(-1, n);
      check("sweep_len_por", 64'(n), 64'd64);
      for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'(i), 6'(63 - i));

      cycle(1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 1'b1, 6'd0, 6'd0);
      cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd5, 6'd5);
      check("w5_rd1", 64'(rd1), 64'hDEADBEEF);
      check("w5_rd2", 64'(rd2), 64'hDEADBEEF);
      check("w5_rg1", 64'(rg1), 64'd1);
      check("w5_rg2", 64'(rg2), 64'd1);

      cycle(1'b0, 1'b1, 6'd0, 32'h12345678, 1'b1, 6'd5, 6'd5);
      cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
      check("r0_rd1", 64'(rd1), 64'd0);
      check("r0_rg1", 64'(rg1), 64'd0);

      cycle(1'b0, 1'b1, 6'd7, 32'h11111111, 1'b0, 6'd0, 6'd0);
      cycle(1'b0, 1'b1, 6'd7, 32'hA5A5A5A5, 1'b1, 6'd7, 6'd7);
      check("rdw_rd1", 64'(rd1), BYP ? 64'hA5A5A5A5 : 64'h11111111);
      cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd7, 6'd0);
      check("rdw_next", 64'(rd1), 64'hA5A5A5A5);

      // clr, re-asserted 10 cycles into the sweep, stretches busy to 74 cycles.
      cycle(1'b0, 1'b1, 6'd9, 32'hCAFEF00D, 1'b0, 6'd0, 6'd0);
      cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd9, 6'd9);
      check("w9_rd1", 64'(rd1), 64'hCAFEF00D);
      cycle(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
      run_sweep(9, n);
      check("sweep_len_reclr", 64'(n), 64'd74);
      cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd9, 6'd3);
      check("clr_rd9", 64'(rd1), 64'd0);
      check("drop_rd3", 64'(rd2), 64'd0);

      // Random traffic concentrated on a few addresses to hit collisions and r0.
      for (int i = 0; i < 600; i++)
         cycle($urandom_range(0, 99) == 0, 1'($urandom), 6'($urandom_range(0, 7)), $urandom,
               1'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)));
      run_sweep(-1, n);

      // Reset 30 cycles into a sweep restarts a full one.
      cycle(1'b1, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0);
      for (int i = 0; i < 30; i++) cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd1, 6'd2);
      do_reset();
      run_sweep(-1, n);
      check("sweep_len_midrst", 64'(n), 64'd64);

      // Asynchronous reset clears live read data immediately.
      cycle(1'b0, 1'b1, 6'd12, 32'h5A5A0F0F, 1'b1, 6'd0, 6'd0);
      cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd12, 6'd12);
      check("pre_rst_rd1", 64'(rd1), 64'h5A5A0F0F);
      do_reset();
      run_sweep(-1, n);
      check("sweep_len_runrst", 64'(n), 64'd64);
      cycle(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd12, 6'd5);
      check("post_rst_rd12", 64'(rd1), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
